// File: rtl/ahb_slv_pkg.sv
// Shared AHB-Lite codes, FSM state type and lane-mask helper
// for the ahb_sram_slave block.
package ahb_slv_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR1,
    ERR2
  } state_e;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] size,
    input logic [1:0] lane
  );
    logic [3:0] be;
    be = 4'h0;
    unique case (1'b1)
      size == HSIZE_BYTE: be = 4'b0001 << lane;
      size == HSIZE_HALF: be = 4'b0011 << lane;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the SRAM slave.
// HREADY is the bus-level ready returned to every slave.
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL,
    output HADDR,
    output HTRANS,
    output HWRITE,
    output HSIZE,
    output HBURST,
    output HPROT,
    output HWDATA,
    output HREADY,
    input  HREADYOUT,
    input  HRESP,
    input  HRDATA
  );

  modport slave (
    input  HSEL,
    input  HADDR,
    input  HTRANS,
    input  HWRITE,
    input  HSIZE,
    input  HBURST,
    input  HPROT,
    input  HWDATA,
    input  HREADY,
    output HREADYOUT,
    output HRESP,
    output HRDATA
  );

endinterface

// File: rtl/ahb_slv_mem.sv
// Word-organised SRAM: byte-enable write port, asynchronous read.
// Contents are deliberately not reset.
module ahb_slv_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: FSM, address latch, error check, byte enables.
// Define AHB_SLV_WAIT_STATE_EN to insert WAIT_STATES cycles per OKAY transfer.
module ahb_sram_slave
  import ahb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic            hclk,
  input logic            hreset,
  ahb_sram_slave_if.slave s
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LW = IW + 2;
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(MEM_DEPTH * 4);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic          wr_q, wr_d;
  logic [LW-1:0] addr_q, addr_d;
  logic [2:0]    size_q, size_d;

  logic          accept;
  logic          bad;
  logic          ready;
  logic          resp;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   rdata;
  logic          unused_ok;

`ifdef AHB_SLV_WAIT_STATE_EN
  localparam int CW =
    (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign unused_ok = ^{s.HBURST, s.HPROT};

  assign accept = s.HSEL && s.HREADY &&
    (s.HTRANS == HTRANS_NONSEQ || s.HTRANS == HTRANS_SEQ);

  always_comb begin
    bad = 1'b0;
    if (s.HADDR >= LIMIT) bad = 1'b1;
    if (s.HSIZE > HSIZE_WORD) bad = 1'b1;
    if (s.HSIZE == HSIZE_HALF && s.HADDR[0]) bad = 1'b1;
    if (s.HSIZE == HSIZE_WORD && s.HADDR[1:0] != 2'b00) bad = 1'b1;
  end

  always_comb begin
    ready = 1'b1;
    resp  = HRESP_OKAY;
    unique case (state_q)
      ERR1: begin
        ready = 1'b0;
        resp  = HRESP_ERROR;
      end
      ERR2: resp = HRESP_ERROR;
`ifdef AHB_SLV_WAIT_STATE_EN
      WAIT: ready = (cnt_q == '0);
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    size_d  = size_q;
`ifdef AHB_SLV_WAIT_STATE_EN
    cnt_d   = cnt_q;
`endif
    if (state_q == ERR1) begin
      state_d = ERR2;
`ifdef AHB_SLV_WAIT_STATE_EN
    end else if (!ready) begin
      cnt_d = cnt_q - CW'(1);
`endif
    end else begin
      // data phase (if any) completes here; next address may be taken
      state_d = IDLE;
      pend_d  = 1'b0;
      if (accept) begin
        wr_d   = s.HWRITE;
        addr_d = s.HADDR[LW-1:0];
        size_d = s.HSIZE;
        if (bad) begin
          state_d = ERR1;
        end else begin
          pend_d = 1'b1;
`ifdef AHB_SLV_WAIT_STATE_EN
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
`ifdef AHB_SLV_WAIT_STATE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
`ifdef AHB_SLV_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign be = lane_mask(size_q, addr_q[1:0]);
  // reset on the completing edge drops the write
  assign we = pend_q && wr_q && ready && !hreset;

  ahb_slv_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (IW)
  ) u_mem (
    .clk   (hclk),
    .we    (we),
    .be    (be),
    .addr  (addr_q[LW-1:2]),
    .wdata (s.HWDATA),
    .rdata (rdata)
  );

  assign s.HREADYOUT = ready;
  assign s.HRESP     = resp;
  assign s.HRDATA    = (pend_q && !wr_q) ? rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed + random bench for ahb_sram_slave against a byte-array model.
// Wait-state expectations follow AHB_SLV_WAIT_STATE_EN.
module tb_ahb_sram_slave;

  localparam int MEM_DEPTH = 1024;
  localparam int BYTES     = MEM_DEPTH * 4;
`ifdef AHB_SLV_WAIT_STATE_EN
  localparam int EW = 2;
`else
  localparam int EW = 0;
`endif

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;
  localparam logic [2:0] SZ_B   = 3'd0;
  localparam logic [2:0] SZ_H   = 3'd1;
  localparam logic [2:0] SZ_W   = 3'd2;

  logic hclk = 1'b0;
  logic hreset;
  int   checks = 0;
  int   errors = 0;

  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_slave #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_STATES (2)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .s      (bus)
  );

  always #5 hclk = ~hclk;

  logic [7:0] ref_mem [BYTES];

  typedef enum int {DP_NONE, DP_OK, DP_ERR} dp_e;
  dp_e         dp_kind  = DP_NONE;
  logic        dp_wr    = 1'b0;
  logic [31:0] dp_addr  = 32'h0;
  logic [2:0]  dp_size  = 3'd0;
  logic [31:0] dp_wdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] sz);
    return (a >= 32'(BYTES)) || (sz > SZ_W) ||
           (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    int base;
    base = int'(a) & ~3;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[base + i];
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd);
    int n;
    int b;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      b = int'(a) + i;
      ref_mem[b] = wd[8*(b % 4) +: 8];
    end
  endtask

  task automatic wait_ready(output int lows);
    lows = 0;
    @(negedge hclk);
    while (bus.HREADYOUT !== 1'b1 && lows < 8) begin
      lows++;
      @(posedge hclk);
      #1;
      @(negedge hclk);
    end
  endtask

  // Drive one address phase while checking the data phase in flight.
  task automatic step(input logic sel, input logic [1:0] tr,
                      input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    int lows;
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    bus.HWDATA = dp_wdata;
    case (dp_kind)
      DP_OK: begin
        wait_ready(lows);
        chk("wait_cycles", 32'(lows), 32'(EW));
        chk("ok_resp", 32'(bus.HRESP), 32'd0);
        chk(dp_wr ? "wr_rdata" : "rd_data", bus.HRDATA,
            dp_wr ? 32'h0 : ref_word(dp_addr));
      end
      DP_ERR: begin
        @(negedge hclk);
        chk("err1_ready", 32'(bus.HREADYOUT), 32'd0);
        chk("err1_resp", 32'(bus.HRESP), 32'd1);
        chk("err1_rdata", bus.HRDATA, 32'h0);
        @(posedge hclk);
        #1;
        @(negedge hclk);
        chk("err2_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("err2_resp", 32'(bus.HRESP), 32'd1);
        chk("err2_rdata", bus.HRDATA, 32'h0);
      end
      default: begin
        @(negedge hclk);
        chk("idle_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("idle_resp", 32'(bus.HRESP), 32'd0);
        chk("idle_rdata", bus.HRDATA, 32'h0);
      end
    endcase
    @(posedge hclk);
    #1;
    if (dp_kind == DP_OK && dp_wr) ref_write(dp_addr, dp_size, dp_wdata);
    dp_wdata = wd;
    if (sel && tr[1]) begin
      dp_kind = is_bad(a, sz) ? DP_ERR : DP_OK;
      dp_wr   = wr;
      dp_addr = a;
      dp_size = sz;
    end else begin
      dp_kind = DP_NONE;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.HSEL   = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = T_IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = SZ_W;
    bus.HBURST = 3'd0;
    bus.HPROT  = 4'b0011;
    bus.HWDATA = 32'h0;
    hreset     = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    // fill words 0..63 back-to-back so later reads are defined
    for (int w = 0; w < 64; w++)
      step(1'b1, T_NSEQ, 1'b1, 32'(w * 4), SZ_W, $urandom);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    step(1'b1, T_NSEQ, 1'b1, 32'h10, SZ_W, 32'hDEADBEEF);
    step(1'b1, T_NSEQ, 1'b0, 32'h10, SZ_W, 32'h0);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    // reset held 3 cycles across a write data phase
    step(1'b1, T_NSEQ, 1'b1, 32'h10, SZ_W, 32'h12345678);
    bus.HSEL   = 1'b0;
    bus.HTRANS = T_IDLE;
    bus.HWDATA = dp_wdata;
    hreset     = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    hreset  = 1'b0;
    dp_kind = DP_NONE;
    step(1'b1, T_NSEQ, 1'b0, 32'h10, SZ_W, 32'h0);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    step(1'b1, T_NSEQ, 1'b1, 32'h20, SZ_W, 32'h00000000);
    step(1'b1, T_NSEQ, 1'b1, 32'h21, SZ_B, 32'h0000AA00);
    step(1'b1, T_NSEQ, 1'b1, 32'h22, SZ_H, 32'h55550000);
    step(1'b1, T_NSEQ, 1'b0, 32'h20, SZ_W, 32'h0);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    step(1'b1, T_NSEQ, 1'b0, 32'(BYTES), SZ_W, 32'h0);
    step(1'b1, T_NSEQ, 1'b1, 32'h3, SZ_W, 32'hFFFFFFFF);
    step(1'b1, T_NSEQ, 1'b0, 32'h0, SZ_W, 32'h0);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    step(1'b0, T_NSEQ, 1'b1, 32'h30, SZ_W, 32'hFFFFFFFF);
    step(1'b1, T_NSEQ, 1'b0, 32'h30, SZ_W, 32'h0);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    bus.HBURST = 3'b011;
    step(1'b1, T_NSEQ, 1'b1, 32'h40, SZ_W, $urandom);
    step(1'b1, T_SEQ,  1'b1, 32'h44, SZ_W, $urandom);
    step(1'b1, T_BUSY, 1'b1, 32'h48, SZ_W, 32'h0);
    step(1'b1, T_SEQ,  1'b1, 32'h48, SZ_W, $urandom);
    step(1'b1, T_SEQ,  1'b1, 32'h4C, SZ_W, $urandom);
    bus.HBURST = 3'b001;
    for (int k = 0; k < 4; k++)
      step(1'b1, (k == 0) ? T_NSEQ : T_SEQ, 1'b0, 32'(32'h40 + k * 4),
           SZ_W, 32'h0);
    bus.HBURST = 3'b000;
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic        sel;
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] a;
      sel = ($urandom_range(0, 7) != 0);
      tr  = 2'($urandom_range(0, 3));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                        : 3'($urandom_range(0, 2));
      a   = ($urandom_range(0, 9) == 0) ? 32'(BYTES + $urandom_range(0, 255))
                                        : 32'($urandom_range(0, 255));
      step(sel, tr, $urandom_range(0, 1) == 1, a, sz, $urandom);
    end
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
